board_shuffler: RTL

BOARD_SHUFFLER -- requirements
Module: board_shuffler

---
 rtl/board_shuffler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/board_shuffler.sv
// board_shuffler: builds a 6x6 board of 18 tile pairs, shuffles it with a
// Fisher-Yates pass driven by a 16-bit Galois LFSR, then streams the tile
// colours out to an external board memory over a simple valid/ready port.
module board_shuffler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ready
);

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [5:0]  LAST_CELL    = 6'd35;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUF,
        WRITE,
        DONE
    } state_t;

    state_t      state_reg;
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic [5:0]  idx_reg;          // k while filling, i while shuffling
    logic [5:0]  idx_plus1;
    logic [5:0]  j_idx;
    logic [4:0]  id_reg  [36];
    logic [4:0]  id_next [36];

    logic        busy_reg;
    logic        done_reg;
    logic        wr_en_reg;
    logic [5:0]  wr_addr_reg;
    logic [7:0]  wr_data_reg;

    // Tile id to colour: 18 distinct non-zero values, 7 + 13*id.
    function automatic logic [7:0] colour(input logic [4:0] tile);
        return ({3'b000, tile} * 8'd13) + 8'd7;
    endfunction

    // Galois LFSR, shifted right, feedback applied when the dropped bit is 1.
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);

    // Scaled random pick: (r * (i+1)) >> 8 always lands in 0..i.
    assign idx_plus1 = idx_reg + 6'd1;
    assign j_idx     = 6'(({6'd0, lfsr_reg[7:0]} * {8'd0, idx_plus1}) >> 8);

    // Next value of the tile array: fill one cell in INIT, swap i/j in SHUF.
    // When j == i both writes carry the same value, so the array is unchanged.
    always_comb begin
        for (int n = 0; n < 36; n++) begin
            id_next[n] = id_reg[n];
        end
        if (state_reg == INIT) begin
            id_next[idx_reg] = idx_reg[5:1];
        end else if (state_reg == SHUF) begin
            id_next[idx_reg] = id_reg[j_idx];
            id_next[j_idx]   = id_reg[idx_reg];
        end
    end

    // Tile array storage; cleared by reset, otherwise follows id_next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 36; n++) begin
                id_reg[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 36; n++) begin
                id_reg[n] <= id_next[n];
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            lfsr_reg    <= LFSR_DEFAULT;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        lfsr_reg  <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= INIT;
                    end
                end
                INIT: begin
                    if (idx_reg == LAST_CELL) begin
                        idx_reg   <= LAST_CELL;
                        state_reg <= SHUF;
                    end else begin
                        idx_reg <= idx_reg + 6'd1;
                    end
                end
                SHUF: begin
                    lfsr_reg <= lfsr_next;
                    if (idx_reg == 6'd1) begin
                        // Cell 0 may be swapped in this very step, so take it
                        // from the post-swap value.
                        state_reg   <= WRITE;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= '0;
                        wr_data_reg <= colour(id_next[0]);
                    end else begin
                        idx_reg <= idx_reg - 6'd1;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        if (wr_addr_reg == LAST_CELL) begin
                            wr_en_reg   <= 1'b0;
                            wr_addr_reg <= '0;
                            wr_data_reg <= '0;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            wr_addr_reg <= wr_addr_reg + 6'd1;
                            wr_data_reg <= colour(id_reg[wr_addr_reg + 6'd1]);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule
